// File: rtl/fft_pkg.sv
// Shared types and helpers for the streaming 4-point DIF FFT engine.
// Holds the FSM state encoding, stage growth constants and output clamping.
package fft_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ST1    = 2'd1,
        ST2    = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    // Bits of growth carried by the stage-1 and stage-2 registers over DATA_W.
    localparam int STAGE1_GROWTH = 1;
    localparam int STAGE2_GROWTH = 2;
    localparam int SAT_MAX_W     = 64;

    // Clamp a sign-extended value to the two's complement range of w bits.
    function automatic logic signed [SAT_MAX_W-1:0] saturate(
        input logic signed [SAT_MAX_W-1:0] x,
        input int                          w
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/fft_bfly2.sv
// Combinational radix-2 butterfly: sum and difference with one bit of growth,
// optionally halved (floor) so the result stays within IN_W bits.
module fft_bfly2 #(
    parameter int IN_W     = 16,
    parameter bit SCALE_EN = 1'b1
) (
    input  logic signed [IN_W-1:0] a_re,
    input  logic signed [IN_W-1:0] a_im,
    input  logic signed [IN_W-1:0] b_re,
    input  logic signed [IN_W-1:0] b_im,
    output logic signed [IN_W:0]   sum_re,
    output logic signed [IN_W:0]   sum_im,
    output logic signed [IN_W:0]   diff_re,
    output logic signed [IN_W:0]   diff_im
);
    logic signed [IN_W:0] s_re, s_im, d_re, d_im;

    always_comb begin
        s_re = (IN_W+1)'(a_re) + (IN_W+1)'(b_re);
        s_im = (IN_W+1)'(a_im) + (IN_W+1)'(b_im);
        d_re = (IN_W+1)'(a_re) - (IN_W+1)'(b_re);
        d_im = (IN_W+1)'(a_im) - (IN_W+1)'(b_im);
        sum_re  = SCALE_EN ? (s_re >>> 1) : s_re;
        sum_im  = SCALE_EN ? (s_im >>> 1) : s_im;
        diff_re = SCALE_EN ? (d_re >>> 1) : d_re;
        diff_im = SCALE_EN ? (d_im >>> 1) : d_im;
    end

endmodule

// File: rtl/dif_fft4_stream.sv
// Streaming 4-point radix-2 DIF FFT: collects four samples, runs two registered
// butterfly stages and returns bins 0..3 in natural order under backpressure.
module dif_fft4_stream
    import fft_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter bit SCALE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              in_inverse,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              out_sat
);
    // LOAD: collect x0..x3 | ST1: stage-1 butterflies | ST2: stage-2 butterflies | UNLOAD: emit bins
    localparam int S1_W = DATA_W + STAGE1_GROWTH;
    localparam int S2_W = DATA_W + STAGE2_GROWTH;

    state_t                   state;
    logic [1:0]               cnt;
    logic                     inv_q;
    logic signed [DATA_W-1:0] xb_re [4];
    logic signed [DATA_W-1:0] xb_im [4];
    logic signed [S1_W-1:0]   a0_re, a0_im, a1_re, a1_im, b0_re, b0_im, b1_re, b1_im;
    logic signed [S2_W-1:0]   xs_re [4];
    logic signed [S2_W-1:0]   xs_im [4];

    logic signed [S1_W-1:0]   p_sum_re, p_sum_im, p_dif_re, p_dif_im;
    logic signed [S1_W-1:0]   q_sum_re, q_sum_im, q_dif_re, q_dif_im;
    logic signed [S1_W-1:0]   rot_re, rot_im, a1_n_re, a1_n_im, b1_n_re, b1_n_im;
    logic signed [S2_W-1:0]   x0c_re, x0c_im, x1c_re, x1c_im, x2c_re, x2c_im, x3c_re, x3c_im;

    logic [1:0]                  nxt_idx;
    logic signed [S2_W-1:0]      pick_re, pick_im;
    logic signed [SAT_MAX_W-1:0] ext_re, ext_im, clp_re, clp_im;
    logic [DATA_W-1:0]           nr_re, nr_im;
    logic                        nr_sat;

    fft_bfly2 #(.IN_W(DATA_W), .SCALE_EN(SCALE_EN)) u_bfly_02 (
        .a_re(xb_re[0]), .a_im(xb_im[0]), .b_re(xb_re[2]), .b_im(xb_im[2]),
        .sum_re(p_sum_re), .sum_im(p_sum_im), .diff_re(p_dif_re), .diff_im(p_dif_im)
    );

    // The x1-x3 difference must be rotated before halving, so this one runs unscaled.
    fft_bfly2 #(.IN_W(DATA_W), .SCALE_EN(1'b0)) u_bfly_13 (
        .a_re(xb_re[1]), .a_im(xb_im[1]), .b_re(xb_re[3]), .b_im(xb_im[3]),
        .sum_re(q_sum_re), .sum_im(q_sum_im), .diff_re(q_dif_re), .diff_im(q_dif_im)
    );

    always_comb begin
        rot_re  = inv_q ? -q_dif_im : q_dif_im;
        rot_im  = inv_q ? q_dif_re : -q_dif_re;
        a1_n_re = SCALE_EN ? (q_sum_re >>> 1) : q_sum_re;
        a1_n_im = SCALE_EN ? (q_sum_im >>> 1) : q_sum_im;
        b1_n_re = SCALE_EN ? (rot_re >>> 1) : rot_re;
        b1_n_im = SCALE_EN ? (rot_im >>> 1) : rot_im;
    end

    fft_bfly2 #(.IN_W(S1_W), .SCALE_EN(SCALE_EN)) u_bfly_a (
        .a_re(a0_re), .a_im(a0_im), .b_re(a1_re), .b_im(a1_im),
        .sum_re(x0c_re), .sum_im(x0c_im), .diff_re(x2c_re), .diff_im(x2c_im)
    );

    fft_bfly2 #(.IN_W(S1_W), .SCALE_EN(SCALE_EN)) u_bfly_b (
        .a_re(b0_re), .a_im(b0_im), .b_re(b1_re), .b_im(b1_im),
        .sum_re(x1c_re), .sum_im(x1c_im), .diff_re(x3c_re), .diff_im(x3c_im)
    );

    // Bin 0 is loaded straight from the stage-2 adders so out_valid rises as ST2 ends.
    always_comb begin
        nxt_idx = out_idx + 2'd1;
        pick_re = xs_re[nxt_idx];
        pick_im = xs_im[nxt_idx];
        if (state == ST2) begin
            pick_re = x0c_re;
            pick_im = x0c_im;
        end
        ext_re = SAT_MAX_W'(pick_re);
        ext_im = SAT_MAX_W'(pick_im);
        clp_re = saturate(ext_re, DATA_W);
        clp_im = saturate(ext_im, DATA_W);
        if (SCALE_EN) begin
            nr_re  = pick_re[DATA_W-1:0];
            nr_im  = pick_im[DATA_W-1:0];
            nr_sat = 1'b0;
        end else begin
            nr_re  = clp_re[DATA_W-1:0];
            nr_im  = clp_im[DATA_W-1:0];
            nr_sat = (clp_re != ext_re) || (clp_im != ext_im);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
            cnt   <= '0;
            inv_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                xb_re[i] <= '0;
                xb_im[i] <= '0;
                xs_re[i] <= '0;
                xs_im[i] <= '0;
            end
            a0_re <= '0; a0_im <= '0; a1_re <= '0; a1_im <= '0;
            b0_re <= '0; b0_im <= '0; b1_re <= '0; b1_im <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        xb_re[cnt] <= in_re;
                        xb_im[cnt] <= in_im;
                        if (cnt == 2'd0) inv_q <= in_inverse;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state    <= ST1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ST1: begin
                    a0_re <= p_sum_re; a0_im <= p_sum_im;
                    b0_re <= p_dif_re; b0_im <= p_dif_im;
                    a1_re <= a1_n_re;  a1_im <= a1_n_im;
                    b1_re <= b1_n_re;  b1_im <= b1_n_im;
                    state <= ST2;
                end
                ST2: begin
                    xs_re[0] <= x0c_re; xs_im[0] <= x0c_im;
                    xs_re[1] <= x1c_re; xs_im[1] <= x1c_im;
                    xs_re[2] <= x2c_re; xs_im[2] <= x2c_im;
                    xs_re[3] <= x3c_re; xs_im[3] <= x3c_im;
                    out_re    <= nr_re;
                    out_im    <= nr_im;
                    out_sat   <= nr_sat;
                    out_idx   <= 2'd0;
                    out_last  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= UNLOAD;
                end
                UNLOAD: begin
                    if (out_valid && out_ready) begin
                        if (out_idx == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_idx   <= 2'd0;
                            in_ready  <= 1'b1;
                            cnt       <= 2'd0;
                            state     <= LOAD;
                        end else begin
                            out_idx  <= nxt_idx;
                            out_last <= (nxt_idx == 2'd3);
                            out_re   <= nr_re;
                            out_im   <= nr_im;
                            out_sat  <= nr_sat;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_dif_fft4_stream.sv
// Scoreboard bench for dif_fft4_stream: one unscaled and one scaled instance share
// the input stream; a DFT-level reference model fills per-instance expected queues.
module tb_dif_fft4_stream;
    localparam int DW  = 16;
    localparam int PER = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          in_inverse = 1'b0;
    logic          out_ready = 1'b1;

    logic          in_ready0, out_valid0, out_last0, out_sat0;
    logic [DW-1:0] out_re0, out_im0;
    logic [1:0]    out_idx0;
    logic          in_ready1, out_valid1, out_last1, out_sat1;
    logic [DW-1:0] out_re1, out_im1;
    logic [1:0]    out_idx1;

    always #(PER/2) clk = ~clk;

    dif_fft4_stream #(.DATA_W(DW), .SCALE_EN(1'b0)) u_s0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse),
        .out_valid(out_valid0), .out_ready(out_ready), .out_re(out_re0), .out_im(out_im0),
        .out_idx(out_idx0), .out_last(out_last0), .out_sat(out_sat0)
    );

    dif_fft4_stream #(.DATA_W(DW), .SCALE_EN(1'b1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse),
        .out_valid(out_valid1), .out_ready(out_ready), .out_re(out_re1), .out_im(out_im1),
        .out_idx(out_idx1), .out_last(out_last1), .out_sat(out_sat1)
    );

    typedef struct {
        int re;
        int im;
        bit sat;
        int idx;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         bp_mode = 1'b0;
    bit         gap_mode = 1'b0;
    time        acc_t;
    logic       stall_prev [2];
    logic [36:0] stall_val [2];

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Unscaled: direct 4-point DFT with W = -j (forward) or +j (inverse), then clamp.
    // Scaled: two radix-2 stages with a floor halving after each, which fixes the rounding.
    function automatic void ref_fft(input int xr[4], input int xi[4], input bit inv,
                                    input bit scale, output int yr[4], output int yi[4],
                                    output bit ys[4]);
        if (!scale) begin
            for (int k = 0; k < 4; k++) begin
                int sr = 0;
                int si = 0;
                for (int n = 0; n < 4; n++) begin
                    int tr = xr[n];
                    int ti = xi[n];
                    int t;
                    repeat ((n * k) % 4) begin
                        t = tr;
                        if (!inv) begin tr = ti;  ti = -t; end
                        else      begin tr = -ti; ti = t;  end
                    end
                    sr += tr;
                    si += ti;
                end
                yr[k] = clamp16(sr);
                yi[k] = clamp16(si);
                ys[k] = (yr[k] != sr) || (yi[k] != si);
            end
        end else begin
            int a0r, a0i, a1r, a1i, b0r, b0i, b1r, b1i, dr, di;
            a0r = (xr[0] + xr[2]) >>> 1;  a0i = (xi[0] + xi[2]) >>> 1;
            a1r = (xr[1] + xr[3]) >>> 1;  a1i = (xi[1] + xi[3]) >>> 1;
            b0r = (xr[0] - xr[2]) >>> 1;  b0i = (xi[0] - xi[2]) >>> 1;
            dr  = xr[1] - xr[3];          di  = xi[1] - xi[3];
            if (!inv) begin b1r = di;  b1i = -dr; end
            else      begin b1r = -di; b1i = dr;  end
            b1r = b1r >>> 1;  b1i = b1i >>> 1;
            yr[0] = (a0r + a1r) >>> 1;  yi[0] = (a0i + a1i) >>> 1;
            yr[1] = (b0r + b1r) >>> 1;  yi[1] = (b0i + b1i) >>> 1;
            yr[2] = (a0r - a1r) >>> 1;  yi[2] = (a0i - a1i) >>> 1;
            yr[3] = (b0r - b1r) >>> 1;  yi[3] = (b0i - b1i) >>> 1;
            for (int k = 0; k < 4; k++) ys[k] = 1'b0;
        end
    endfunction

    task automatic push_vals(input int d, input int yr[4], input int yi[4], input bit ys[4]);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.re = yr[k]; e.im = yi[k]; e.sat = ys[k]; e.idx = k;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic push_model(input int d, input int xr[4], input int xi[4], input bit inv);
        int yr[4];
        int yi[4];
        bit ys[4];
        ref_fft(xr, xi, inv, d[0], yr, yi, ys);
        push_vals(d, yr, yi, ys);
    endtask

    task automatic mon(input int d, input logic v, input logic [DW-1:0] re,
                       input logic [DW-1:0] im, input logic [1:0] idx, input logic last,
                       input logic sat, input logic rdy);
        exp_t        e;
        logic [36:0] cur;
        bit          empty;
        cur = {v, re, im, idx, last, sat};
        if (stall_prev[d]) chk($sformatf("stall_hold%0d", d), int'(cur == stall_val[d]), 1);
        if (v) chk($sformatf("in_ready_busy%0d", d), int'(rdy), 0);
        if (v && out_ready) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                chk($sformatf("unexpected_out%0d", d), 1, 0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("re%0d_bin%0d", d, e.idx), int'($signed(re)), e.re);
                chk($sformatf("im%0d_bin%0d", d, e.idx), int'($signed(im)), e.im);
                chk($sformatf("sat%0d_bin%0d", d, e.idx), int'(sat), int'(e.sat));
                chk($sformatf("idx%0d", d), int'(idx), e.idx);
                chk($sformatf("last%0d_bin%0d", d, e.idx), int'(last), int'(e.idx == 3));
            end
        end
        stall_prev[d] = v && !out_ready;
        stall_val[d]  = cur;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            stall_prev[0] = 1'b0;
            stall_prev[1] = 1'b0;
        end else begin
            mon(0, out_valid0, out_re0, out_im0, out_idx0, out_last0, out_sat0, in_ready0);
            mon(1, out_valid1, out_re1, out_im1, out_idx1, out_last1, out_sat1, in_ready1);
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? ($urandom_range(99) < 30) : 1'b1;
    end

    // Entered and left at a negedge; acc_t records the accepting edge.
    task automatic send_sample(input int re, input int im, input bit inv);
        int budget = 0;
        if (gap_mode) begin
            repeat ($urandom_range(2)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid   = 1'b1;
        in_re      = re[DW-1:0];
        in_im      = im[DW-1:0];
        in_inverse = inv;
        while (!(in_ready0 && in_ready1)) begin
            @(negedge clk);
            budget++;
            if (budget > 300) begin
                $display("FAIL in_ready_timeout: got 0, expected 1 within 300 cycles");
                $fatal(1, "input stream stuck");
            end
        end
        @(posedge clk);
        acc_t = $time;
        @(negedge clk);
    endtask

    task automatic send_frame(input int xr[4], input int xi[4], input bit inv[4], output time t0);
        t0 = 0;
        for (int i = 0; i < 4; i++) begin
            send_sample(xr[i], xi[i], inv[i]);
            if (i == 0) t0 = acc_t;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while ((q0.size() != 0 || q1.size() != 0) && b < 600) begin
            @(negedge clk);
            b++;
        end
        chk("drain_pending", q0.size() + q1.size(), 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid0"}, int'(out_valid0), 0);
        chk({tag, "_re0"},    int'(out_re0), 0);
        chk({tag, "_im0"},    int'(out_im0), 0);
        chk({tag, "_idx0"},   int'(out_idx0), 0);
        chk({tag, "_last0"},  int'(out_last0), 0);
        chk({tag, "_sat0"},   int'(out_sat0), 0);
        chk({tag, "_valid1"}, int'(out_valid1), 0);
        chk({tag, "_re1"},    int'(out_re1), 0);
        chk({tag, "_im1"},    int'(out_im1), 0);
    endtask

    function automatic int rnd_s16(input bit full);
        logic [15:0] r;
        if (full) begin
            r = 16'($urandom);
            return int'($signed(r));
        end
        return int'($urandom_range(2000)) - 1000;
    endfunction

    initial begin
        int  xr[4];
        int  xi[4];
        bit  inv[4];
        int  yr[4];
        int  yi[4];
        bit  ys[4];
        time t0;
        time tprev;
        int  b;

        stall_prev[0] = 1'b0;
        stall_prev[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset0", int'(in_ready0), 1);
        chk("in_ready_after_reset1", int'(in_ready1), 1);

        // Forward, x = 1,2,3,4, plus latency of out_valid
        xr = '{1, 2, 3, 4}; xi = '{0, 0, 0, 0}; inv = '{0, 0, 0, 0};
        yr = '{10, -2, -2, -2}; yi = '{0, 2, 0, -2}; ys = '{0, 0, 0, 0};
        push_vals(0, yr, yi, ys);
        push_model(1, xr, xi, 1'b0);
        send_frame(xr, xi, inv, t0);
        chk("lat_st1_valid", int'(out_valid0), 0);
        @(negedge clk);
        chk("lat_st2_valid", int'(out_valid0), 0);
        @(negedge clk);
        chk("lat_third_cycle_valid", int'(out_valid0), 1);
        drain();

        // Inverse latched on sample 0; later toggles ignored
        inv = '{1, 0, 1, 0};
        yr = '{10, -2, -2, -2}; yi = '{0, -2, 0, 2};
        push_vals(0, yr, yi, ys);
        push_model(1, xr, xi, 1'b1);
        send_frame(xr, xi, inv, t0);
        drain();

        // Constant 100: scaled instance returns 100,0,0,0
        xr = '{100, 100, 100, 100}; inv = '{0, 1, 1, 1};
        yr = '{100, 0, 0, 0}; yi = '{0, 0, 0, 0};
        push_model(0, xr, xi, 1'b0);
        push_vals(1, yr, yi, ys);
        send_frame(xr, xi, inv, t0);
        drain();

        // Constant 16000: unscaled bin 0 saturates, others do not
        xr = '{16000, 16000, 16000, 16000}; inv = '{0, 0, 0, 0};
        yr = '{32767, 0, 0, 0}; ys = '{1, 0, 0, 0};
        push_vals(0, yr, yi, ys);
        push_model(1, xr, xi, 1'b0);
        send_frame(xr, xi, inv, t0);
        drain();

        // Reset after two samples of a frame
        send_sample(7, -3, 1'b0);
        send_sample(-9, 4, 1'b1);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk_idle("rst_load");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        xr = '{5, -6, 7, -8}; xi = '{-1, 2, -3, 4}; inv = '{1, 0, 0, 0};
        push_model(0, xr, xi, 1'b1);
        push_model(1, xr, xi, 1'b1);
        send_frame(xr, xi, inv, t0);
        drain();

        // Reset in UNLOAD once bin 1 has been accepted
        xr = '{300, -200, 1000, 77}; xi = '{12, 34, -56, 78}; inv = '{0, 0, 0, 0};
        push_model(0, xr, xi, 1'b0);
        push_model(1, xr, xi, 1'b0);
        send_frame(xr, xi, inv, t0);
        b = 0;
        do begin
            @(negedge clk);
            #1;
            b++;
        end while (q0.size() > 2 && b < 50);
        chk("reach_bin1", q0.size(), 2);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_idle("rst_unload");
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        xr = '{-32768, 32767, -32768, 32767}; xi = '{32767, 32767, -32768, -32768};
        inv = '{0, 1, 1, 1};
        push_model(0, xr, xi, 1'b0);
        push_model(1, xr, xi, 1'b0);
        send_frame(xr, xi, inv, t0);
        drain();

        // 100 back-to-back random frames, checking the 10-cycle period
        tprev = 0;
        for (int f = 0; f < 100; f++) begin
            bit full = $urandom_range(1);
            for (int i = 0; i < 4; i++) begin
                xr[i] = rnd_s16(full);
                xi[i] = rnd_s16(full);
                inv[i] = $urandom_range(1);
            end
            push_model(0, xr, xi, inv[0]);
            push_model(1, xr, xi, inv[0]);
            send_frame(xr, xi, inv, t0);
            if (f > 0) chk("frame_period", int'(t0 - tprev), 10 * PER);
            tprev = t0;
        end
        drain();

        // Random frames with output backpressure and input gaps
        bp_mode  = 1'b1;
        gap_mode = 1'b1;
        for (int f = 0; f < 60; f++) begin
            bit full = $urandom_range(1);
            for (int i = 0; i < 4; i++) begin
                xr[i] = rnd_s16(full);
                xi[i] = rnd_s16(full);
                inv[i] = $urandom_range(1);
            end
            push_model(0, xr, xi, inv[0]);
            push_model(1, xr, xi, inv[0]);
            send_frame(xr, xi, inv, t0);
        end
        drain();
        bp_mode  = 1'b0;
        gap_mode = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
